// File: rtl/resc_rr_scheduler.sv
// resc_rr_scheduler
//   Round-robin front end for one shared ReSC wrapper. Two requesters compete
//   for the wrapper; one job is outstanding at a time. The wrapper is started
//   with a one-cycle pulse and must answer with resc_done within TIMEOUT
//   cycles, otherwise the owner receives an error response.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   req{0,1}_valid/_x/_ready   sample request handshake per requester
//   resp{0,1}_valid/_y/_err    result held for the owning requester
//   resp{0,1}_ready            requester consumes its result
//   resc_x_bin, resc_start     operand and start pulse to the wrapper
//   resc_done, resc_y_bin      completion pulse and result from the wrapper
//   busy                       high whenever a job is in flight
module resc_rr_scheduler #(
    parameter int WIDTH   = 10,
    parameter int TIMEOUT = 2047
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_x,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_x,
    output logic             req1_ready,
    output logic             resp0_valid,
    output logic [WIDTH-1:0] resp0_y,
    output logic             resp0_err,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    output logic [WIDTH-1:0] resp1_y,
    output logic             resp1_err,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resc_x_bin,
    output logic             resc_start,
    input  logic             resc_done,
    input  logic [WIDTH-1:0] resc_y_bin,
    output logic             busy
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

    state_t             state_q, state_d;
    logic               owner_q;
    logic               last_q;
    logic [WIDTH-1:0]   x_q;
    logic [WIDTH-1:0]   y_q;
    logic               err_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_inc;
    logic               grant;
    logic               accept;
    logic               timeout_hit;
    logic               resp_hs;

    // On a tie the requester that was not served last wins.
    assign grant   = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    assign accept  = (state_q == IDLE) && (req0_valid || req1_valid);

    // The counter is cleared in ISSUE and steps once per BUSY cycle; the
    // timeout fires in the BUSY cycle in which it steps onto TIMEOUT, so the
    // error response appears TIMEOUT+1 cycles after the start pulse.
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));

    assign resp_hs = (state_q == RESP) && (owner_q ? resp1_ready : resp0_ready);

    assign req0_ready  = accept && !grant;
    assign req1_ready  = accept && grant;
    assign resc_start  = (state_q == ISSUE);
    assign busy        = (state_q != IDLE);
    assign resc_x_bin  = x_q;

    assign resp0_valid = (state_q == RESP) && !owner_q;
    assign resp1_valid = (state_q == RESP) && owner_q;
    assign resp0_y     = resp0_valid ? y_q : '0;
    assign resp1_y     = resp1_valid ? y_q : '0;
    assign resp0_err   = resp0_valid && err_q;
    assign resp1_err   = resp1_valid && err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = BUSY;
            BUSY:    if (resc_done || timeout_hit) state_d = RESP;
            RESP:    if (resp_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            x_q     <= '0;
            y_q     <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        owner_q <= grant;
                        x_q     <= grant ? req1_x : req0_x;
                    end
                end
                ISSUE: begin
                    cnt_q <= '0;
                end
                BUSY: begin
                    cnt_q <= cnt_inc;
                    // A completion in the timeout cycle still counts as success.
                    if (resc_done) begin
                        y_q   <= resc_y_bin;
                        err_q <= 1'b0;
                    end else if (timeout_hit) begin
                        y_q   <= '0;
                        err_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_hs) last_q <= owner_q;
                end
                default: ;
            endcase
        end
    end

endmodule
